decode_shadow_ctrl: RTL and testbench
=====================================

# decode_shadow_ctrl

Front-end sequencer between fetch and the decode unit: owns the single decode-stage instruction register, drives the decoder's instruction and under-shadow inputs, and runs the short-forward-branch (SFO) shadow window. When a conditional branch with a small positive offset is handed downstream, it tracks how many following instructions fall inside the branch shadow. It cancels the window if a non-shadowable instruction appears inside it. Sits after the fetch queue and before rename, with valid/ready handshakes on both sides.

## Interface
- MAX_SHADOW, 4, maximum number of instructions a shadow window may cover (≥1)
- CW, $clog2(MAX_SHADOW+1), shadow counter width (derived, not overridden)

- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  pipeline flush (mispredict/exception)
- f_valid  in  1  fetch has an instruction
- f_instr  in  32  fetched instruction
- f_pc  in  32  its PC
- f_ready  out  1  decode register can accept
- d_valid  out  1  decode register holds a valid instruction
- d_ready  in  1  downstream (rename) accepts this cycle
- d_instr  out  32  instruction to decoder (dc.instr)
- d_pc  out  32  its PC
- dec_cond_branch  in  1  decoder: d_instr is a conditional branch (bctrl branch bit)
- dec_shadowable  in  1  decoder: d_instr is shadowable (bctrl shadowable bit)
- d_under_shadow  out  1  d_instr lies in an open shadow (dc.under_shadow)
- d_sfo_open  out  1  d_instr is the branch opening a shadow window
- sfo_cancel  out  1  open window cancelled by the instruction handed off this cycle

## Operation
- Register: one entry {valid, instr, pc}. f_ready = rst_n & !flush & (!d_valid | d_ready). Load when f_valid & f_ready. Clear valid on handoff (d_valid & d_ready) when nothing loads.
- dec_cond_branch and dec_shadowable are combinational from d_instr through the decoder. They are only sampled when d_valid=1.
- Offset: off = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, 13-bit signed.
- SFO-eligible when all hold: dec_cond_branch, instr[31]=0, and 8 ≤ off ≤ 4·(MAX_SHADOW+1). Window length n = off[12:2] − 1, truncated to CW bits.
- Counter cnt[CW-1:0] holds the remaining shadowed instructions.
- d_under_shadow = d_valid & (cnt≠0).
- d_sfo_open = d_valid & (cnt=0) & SFO-eligible.
- sfo_cancel = d_valid & d_ready & (cnt≠0) & !dec_shadowable.
- Counter update applies only on handoff, in priority order:
  - flush → cnt=0.
  - cnt≠0 & dec_shadowable → cnt−1.
  - cnt≠0 & !dec_shadowable → cnt=0 (cancel). The cancelling instruction still reports d_under_shadow=1. A branch inside a window is non-shadowable, so it cancels and never nests.
  - cnt=0 & SFO-eligible → cnt=n.
  - otherwise cnt unchanged.
- Flush: clears valid and cnt regardless of handshake. No instruction is accepted in the flush cycle.

## Timing
- Reset (rst_n=0 at a clk edge): d_valid=0, d_instr=32'h0000_0013, d_pc=0, cnt=0. This gives d_under_shadow=0, d_sfo_open=0, sfo_cancel=0. f_ready=0 while rst_n=0.
- Latency: f_instr accepted at edge N is presented on d_instr/d_valid after edge N. Throughput is one instruction per cycle when d_ready=1 continuously.
- Stall (d_valid & !d_ready): d_instr, d_pc, cnt and d_under_shadow/d_sfo_open hold stable. sfo_cancel=0.
- Window closes naturally: the n-th shadowed instruction is handed off with cnt=1. The next instruction sees cnt=0.
- flush together with f_valid: flush wins. Next cycle d_valid=0, cnt=0.
- Reset mid-window has the same result as flush, plus the reset values above.

## Test plan
- Reset: rst_n=0 for 2 cycles with f_valid=1 → f_ready=0, d_valid=0. After release, f_ready=1 and the first instruction appears 1 cycle after acceptance.
- SFO window: beq x0,x0,+12 (32'h0000_0663), then three addi (32'h0010_0093, shadowable), d_ready=1 → branch has d_sfo_open=1. Next two have d_under_shadow=1, the third has 0, and sfo_cancel never fires.
- Cancel: 32'h0000_0663, then jal (dec_shadowable=0), then addi → jal shows d_under_shadow=1 and sfo_cancel=1 at its handoff. The addi shows d_under_shadow=0.
- Non-eligible offsets with MAX_SHADOW=4: offsets −8, +4 and +24 → d_sfo_open=0. Following instructions are not under shadow. +20 → d_sfo_open=1 with 4 shadowed instructions.
- Backpressure: inside a window, d_ready=0 for 3 cycles → f_ready=0, outputs and cnt frozen. After release the count resumes with no instruction lost or duplicated.
- Flush: assert flush with f_valid=1 while cnt=2 → next cycle d_valid=0, d_under_shadow=0. The following branch-free instructions are not under shadow.

Source files
------------

// File: rtl/decode_shadow_ctrl.sv
// Decode-stage instruction register and short-forward-branch shadow sequencer.
// Tracks how many instructions after an eligible branch fall in its shadow.
module decode_shadow_ctrl #(
    parameter int MAX_SHADOW = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        f_valid,
    input  logic [31:0] f_instr,
    input  logic [31:0] f_pc,
    output logic        f_ready,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    input  logic        dec_cond_branch,
    input  logic        dec_shadowable,
    output logic        d_under_shadow,
    output logic        d_sfo_open,
    output logic        sfo_cancel,
    output logic        dbg_state
);

    localparam int          CW      = $clog2(MAX_SHADOW + 1);
    localparam logic [12:0] OFF_MIN = 13'd8;
    localparam logic [12:0] OFF_MAX = 13'(4 * (MAX_SHADOW + 1));
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SHADOW = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load;
    logic          handoff;
    logic [12:0]   off;
    logic          sfo_eligible;
    logic [CW-1:0] win_len;

    // Handshakes: a transfer happens on a side exactly when its valid and ready
    // are both high at the rising edge; valid never depends on ready.
    assign f_ready = rst_n & ~flush & (~d_valid | d_ready);
    assign load    = f_valid & f_ready;
    assign handoff = d_valid & d_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_valid <= 1'b0;
            d_instr <= NOP;
            d_pc    <= '0;
        end else if (flush) begin
            d_valid <= 1'b0;
        end else if (load) begin
            d_valid <= 1'b1;
            d_instr <= f_instr;
            d_pc    <= f_pc;
        end else if (handoff) begin
            d_valid <= 1'b0;
        end
    end

    // B-type immediate; bit 31 clear restricts eligibility to forward branches.
    always_comb begin
        off          = {d_instr[31], d_instr[7], d_instr[30:25], d_instr[11:8], 1'b0};
        sfo_eligible = dec_cond_branch & ~d_instr[31] & (off >= OFF_MIN) & (off <= OFF_MAX);
        win_len      = CW'(off[12:2] - 11'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (handoff) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (sfo_eligible) begin
                        state_d = ST_SHADOW;
                        cnt_d   = win_len;
                    end
                end
                ST_SHADOW: begin
                    // Last shadowed slot or a non-shadowable instruction closes the window.
                    if (dec_shadowable && (cnt_q != CW'(1))) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        d_under_shadow = d_valid & (state_q == ST_SHADOW);
        d_sfo_open     = d_valid & (state_q == ST_IDLE) & sfo_eligible;
        sfo_cancel     = handoff & (state_q == ST_SHADOW) & ~dec_shadowable;
        dbg_state      = state_q;
    end

endmodule

// File: tb/tb_decode_shadow_ctrl.sv
// Bench for decode_shadow_ctrl: directed scenarios plus random traffic checked
// against an instruction-order queue and an integer shadow-window model.
module tb_decode_shadow_ctrl;

    localparam int MAX_SHADOW = 4;

    logic        clk = 1'b0;
    logic        rst_n, flush, f_valid, f_ready, d_valid, d_ready;
    logic [31:0] f_instr, f_pc, d_instr, d_pc;
    logic        dec_cond_branch, dec_shadowable;
    logic        d_under_shadow, d_sfo_open, sfo_cancel, dbg_state;

    always #5 clk = ~clk;

    decode_shadow_ctrl #(.MAX_SHADOW(MAX_SHADOW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .f_valid(f_valid), .f_instr(f_instr), .f_pc(f_pc), .f_ready(f_ready),
        .d_valid(d_valid), .d_ready(d_ready), .d_instr(d_instr), .d_pc(d_pc),
        .dec_cond_branch(dec_cond_branch), .dec_shadowable(dec_shadowable),
        .d_under_shadow(d_under_shadow), .d_sfo_open(d_sfo_open),
        .sfo_cancel(sfo_cancel), .dbg_state(dbg_state)
    );

    // Decoder stand-in: only simple ALU ops may sit in a shadow.
    function automatic logic is_branch(input logic [31:0] i);
        return i[6:0] == 7'h63;
    endfunction

    function automatic logic is_shadowable(input logic [31:0] i);
        return i[6:0] inside {7'h13, 7'h33, 7'h37, 7'h17};
    endfunction

    assign dec_cond_branch = is_branch(d_instr);
    assign dec_shadowable  = is_shadowable(d_instr);

    function automatic int br_off(input logic [31:0] i);
        logic [12:0] b;
        b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        return int'($signed(b));
    endfunction

    // Number of instructions a branch shadows, 0 if it opens no window.
    function automatic int win_len(input logic [31:0] i);
        int o;
        o = br_off(i);
        if (is_branch(i) && o >= 8 && o <= 4 * (MAX_SHADOW + 1)) return o / 4 - 1;
        return 0;
    endfunction

    function automatic logic [31:0] enc_br(input int o, input logic [2:0] f3);
        logic [12:0] im;
        im = 13'(o);
        return {im[12], im[10:5], 5'd2, 5'd1, f3, im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, rd, 7'h13};
    endfunction

    localparam logic [31:0] ADDI = 32'h0010_0093;
    localparam logic [31:0] JAL  = 32'h0000_006F;
    localparam logic [31:0] BEQ12 = 32'h0000_0663;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [63:0] exp_q[$];
    logic [63:0] stim_q[$];
    int          rem = 0;
    logic        reset_vals = 1'b0;
    logic        exp_fr;
    logic        drv_fire = 1'b0;
    logic [31:0] pc_next = 32'h0000_1000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: compares at the negative edge, then advances the model
    // to what the coming rising edge should produce.
    always @(negedge clk) begin
        logic        fv;
        logic [31:0] fi, fp;
        exp_fr = rst_n && !flush && (exp_q.size() == 0 || d_ready);
        fv     = exp_q.size() != 0;
        fi     = fv ? exp_q[0][31:0] : 32'h0;
        fp     = fv ? exp_q[0][63:32] : 32'h0;
        check("f_ready", {31'h0, f_ready}, {31'h0, exp_fr});
        check("d_valid", {31'h0, d_valid}, {31'h0, fv});
        check("dbg_state", {31'h0, dbg_state}, {31'h0, rem > 0});
        if (reset_vals) begin
            check("reset_instr", d_instr, 32'h0000_0013);
            check("reset_pc", d_pc, 32'h0);
        end
        if (fv) begin
            check("d_instr", d_instr, fi);
            check("d_pc", d_pc, fp);
            check("under_shadow", {31'h0, d_under_shadow}, {31'h0, rem > 0});
            check("sfo_open", {31'h0, d_sfo_open}, {31'h0, rem == 0 && win_len(fi) > 0});
            check("sfo_cancel", {31'h0, sfo_cancel},
                  {31'h0, d_ready && rem > 0 && !is_shadowable(fi)});
        end else begin
            check("under_shadow_idle", {31'h0, d_under_shadow}, 32'h0);
            check("sfo_open_idle", {31'h0, d_sfo_open}, 32'h0);
            check("sfo_cancel_idle", {31'h0, sfo_cancel}, 32'h0);
        end
        if (!rst_n || flush) begin
            exp_q.delete();
            rem = 0;
            if (!rst_n) reset_vals = 1'b1;
        end else begin
            if (fv && d_ready) begin
                if (rem > 0) rem = is_shadowable(fi) ? rem - 1 : 0;
                else         rem = win_len(fi);
                void'(exp_q.pop_front());
            end
            if (f_valid && exp_fr) begin
                exp_q.push_back({f_pc, f_instr});
                reset_vals = 1'b0;
            end
        end
    end

    task automatic push_instr(input logic [31:0] i);
        stim_q.push_back({pc_next, i});
        pc_next += 32'd4;
    endtask

    task automatic cycle(input int rdy_pct, input logic fl);
        if (drv_fire) void'(stim_q.pop_front());
        drv_fire = 1'b0;
        f_valid  = stim_q.size() != 0;
        if (f_valid) begin
            f_pc    = stim_q[0][63:32];
            f_instr = stim_q[0][31:0];
        end
        d_ready = $urandom_range(99) < rdy_pct;
        flush   = fl;
        @(negedge clk);
        drv_fire = f_valid & f_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int rdy_pct);
        int n;
        n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && n < 300) begin
            cycle(rdy_pct, 1'b0);
            n++;
        end
        vec_cnt++;
        if (stim_q.size() != 0 || exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL drain: %0d stimuli and %0d expected entries left, required 0",
                     stim_q.size(), exp_q.size());
        end
    endtask

    task automatic wait_rem(input int target, input string name);
        int n;
        n = 0;
        while (!(rem == target && exp_q.size() != 0) && n < 30) begin
            cycle(100, 1'b0);
            n++;
        end
        vec_cnt++;
        if (n >= 30) begin
            err_cnt++;
            $display("FAIL %s: window count %0d, required %0d", name, rem, target);
        end
    endtask

    initial begin
        int offs[] = '{-8, 4, 24, 20};
        rst_n   = 1'b0;
        flush   = 1'b0;
        f_valid = 1'b0;
        f_instr = '0;
        f_pc    = '0;
        d_ready = 1'b0;

        // Reset with fetch offering an instruction.
        push_instr(ADDI);
        cycle(100, 1'b0);
        cycle(100, 1'b0);
        rst_n = 1'b1;
        drain(100);

        // Window of two behind beq +12, never cancelled.
        push_instr(BEQ12);
        repeat (3) push_instr(ADDI);
        drain(100);

        // Cancel by a jal inside the window.
        push_instr(BEQ12);
        push_instr(JAL);
        push_instr(ADDI);
        drain(100);

        // Offset boundaries.
        foreach (offs[k]) begin
            push_instr(enc_br(offs[k], 3'b000));
            repeat (5) push_instr(ADDI);
            drain(100);
        end

        // Backpressure inside a four-deep window.
        push_instr(enc_br(20, 3'b001));
        repeat (5) push_instr(enc_addi(5'd3, 12'h7));
        wait_rem(4, "bp_window_open");
        repeat (3) cycle(0, 1'b0);
        drain(100);

        // Flush while two shadow slots remain, fetch still offering.
        push_instr(BEQ12);
        repeat (3) push_instr(ADDI);
        wait_rem(2, "flush_window_open");
        cycle(100, 1'b1);
        drain(100);

        // Random traffic with stalls, flushes and the odd reset.
        for (int c = 0; c < 1500; c++) begin
            if (stim_q.size() < 4 && $urandom_range(99) < 80) begin
                case ($urandom_range(5))
                    0, 1: push_instr(enc_addi(5'($urandom_range(31)), 12'($urandom_range(4095))));
                    2: push_instr(enc_br(2 * $urandom_range(-8, 16), 3'($urandom_range(7))));
                    3: push_instr(enc_br(2 * $urandom_range(4, 10), 3'b000));
                    4: push_instr($urandom_range(1) ? JAL : 32'h0000_2083);
                    default: push_instr(32'h0020_81B3);
                endcase
            end
            rst_n = $urandom_range(199) != 0;
            cycle(70, $urandom_range(99) < 3);
        end
        rst_n = 1'b1;
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
